ejer2_onchip_memory_arbiter: RTL and testbench
==============================================

// Module: ejer2_onchip_memory_arbiter
// PURPOSE
//  Shares one single-port 8192x32 on-chip RAM (1-cycle read latency, byte enables) between two
//  Avalon-MM requesters (port 0, port 1). Grants one transfer per cycle with round-robin or fixed priority.
//  Routes read data back to the owning port with readdatavalid. Sits between the system interconnect and the RAM.
// PARAMETERS
//  ADDR_W     13   word address width (8192 words)
//  DATA_W     32   data width; BE_W = DATA_W/8 (4)
//  FIXED_PRIO 0    0 = round-robin; 1 = port 0 always wins a tie
// PORTS
//  clk               in   1       single clock for all logic
//  reset             in   1       synchronous, active-high
//  p0_address        in   ADDR_W  port 0 word address (p1_* identical)
//  p0_byteenable     in   BE_W    port 0 byte lanes
//  p0_read           in   1       port 0 read request
//  p0_write          in   1       port 0 write request
//  p0_writedata      in   DATA_W  port 0 write data
//  p0_waitrequest    out  1       port 0 stall; request must be held while high
//  p0_readdata       out  DATA_W  port 0 read data
//  p0_readdatavalid  out  1       port 0 read data valid
//  mem_address       out  ADDR_W  RAM address
//  mem_byteenable    out  BE_W    RAM byte enables
//  mem_chipselect    out  1       RAM select
//  mem_write         out  1       RAM write
//  mem_writedata     out  DATA_W  RAM write data
//  mem_clken         out  1       RAM clock enable
//  mem_readdata      in   DATA_W  RAM data, valid one cycle after a read is issued
//  proto_err         out  1       sticky: read and write asserted together on one port
// BEHAVIOUR
//  - Request: pN_req = pN_read | pN_write. Grant is combinational from req and last_grant.
//  - Single request: that port is granted. Both requesting:
//    - FIXED_PRIO=1: port 0 wins.
//    - FIXED_PRIO=0: the port not in last_grant wins.
//  - last_grant updates only on a granted transfer. Reset value = port 1, so port 0 wins the first tie.
//  - pN_waitrequest = pN_req & ~grantN. Grant is one cycle per transfer, so there is no wait state for the winner.
//  - Memory side, granted cycle:
//    - mem_* = the granted port's fields; mem_chipselect = 1.
//    - mem_write = the granted port's write.
//    - mem_byteenable = pN_byteenable on writes, all ones on reads.
//  - No grant: mem_chipselect = 0, mem_write = 0. Address and data are don't-care; hold the last value.
//  - mem_clken = ~reset.
//  - Read latency: read issued in cycle N gives pN_readdatavalid = 1 in N+1, with pN_readdata = mem_readdata.
//    - Owner is tracked by 1-bit registers rd_pend and rd_owner.
//    - Back-to-back reads sustain 1 per cycle, alternating ports allowed.
//  - Write latency: completes in the grant cycle. No readdatavalid.
//  - Read in N+1 of the address written in N returns the new data.
//  - pN_readdata of a non-owner port = 0. readdatavalid is never asserted on both ports in one cycle.
//  - Read and write together on one port: treated as a write; proto_err is set and cleared only by reset.
//  - Reset (any cycle, including with a read pending):
//    - Registers clear: rd_pend = 0, both readdatavalid = 0, proto_err = 0, last_grant = port 1.
//    - Waitrequest follows req during reset. No grant while reset = 1; mem_chipselect = 0.
//    - A read issued the cycle before reset asserts is dropped (no readdatavalid).
// STRUCTURE
//  - Package ejer2_onchip_mem_pkg holds:
//    - ADDR_W, DATA_W, BE_W localparams.
//    - typedef port_id_t (1 bit): PORT0 = 0, PORT1 = 1.
//    - Reset values of last_grant.
//  - Sub-module ejer2_arb2_rr: pure 2-way arbiter.
//    - Inputs: req[1:0], last_grant, fixed_prio, advance.
//    - Output: grant[1:0], one-hot or zero.
//    - Holds the last_grant register.
//  - Top level holds the mux, the read-return pipeline and proto_err.
// TESTING
//  1. Reset held 3 cycles with p0_read=1 -> p0_waitrequest=1, mem_chipselect=0, no readdatavalid.
//  2. p0 writes 0xDEADBEEF to 0x0010 (be=4'hF), then p0 reads 0x0010 ->
//     mem_write=1 in cycle 1; p0_readdatavalid=1 with 0xDEADBEEF two cycles after the write.
//  3. Byte lanes: p1 writes 0x000000AA be=4'h1 over 0x11223344, then reads -> readdata = 0x112233AA.
//  4. Contention, FIXED_PRIO=0: p0 and p1 read continuously for 6 cycles ->
//     grants p0,p1,p0,p1,p0,p1; each waitrequest alternates; each readdatavalid alternates, one cycle late.
//  5. Contention, FIXED_PRIO=1: both request for 4 cycles -> p0 is granted every cycle; p1_waitrequest stays 1.
//  6. Error/reset: p1_read=p1_write=1 -> treated as a write, proto_err=1 and stays 1.
//     Then a p0 read followed by reset in the next cycle -> no p0_readdatavalid; proto_err returns to 0.

Source files
------------

// File: rtl/ejer2_onchip_mem_pkg.sv
// ejer2_onchip_mem_pkg
//   Shared widths, port identifiers and reset values for the two-port
//   on-chip memory arbiter and its round-robin arbiter sub-block.
package ejer2_onchip_mem_pkg;

  localparam int ADDR_W = 13;
  localparam int DATA_W = 32;
  localparam int BE_W   = DATA_W / 8;

  typedef enum logic {
    PORT0 = 1'b0,
    PORT1 = 1'b1
  } port_id_t;

  // Port 1 is "last served" out of reset so port 0 wins the very first tie.
  localparam port_id_t LAST_GRANT_RST = PORT1;

  // Converts a one-hot (or zero) grant vector into a port identifier.
  function automatic port_id_t grant_to_id(input logic [1:0] grant);
    return grant[1] ? PORT1 : PORT0;
  endfunction

endpackage

// File: rtl/ejer2_arb2_rr.sv
// ejer2_arb2_rr
//   Two-way arbiter with selectable round-robin or fixed priority.
//   Ports:
//     clk, reset   single clock, synchronous active-high reset
//     req[1:0]     request per port (bit 0 = port 0)
//     fixed_prio   1 = port 0 always wins a tie, 0 = round-robin
//     advance      a transfer was granted this cycle; record its winner
//     grant[1:0]   one-hot or zero grant, combinational from req
//     last_grant   port that won the most recent granted transfer
module ejer2_arb2_rr
  import ejer2_onchip_mem_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic [1:0] req,
  input  logic       fixed_prio,
  input  logic       advance,
  output logic [1:0] grant,
  output port_id_t   last_grant
);

  // Only granted transfers move the round-robin pointer, so idle cycles
  // do not disturb fairness.
  always_ff @(posedge clk) begin
    if (reset) begin
      last_grant <= LAST_GRANT_RST;
    end else if (advance) begin
      last_grant <= grant_to_id(grant);
    end
  end

  // On a tie the port that was not served last wins, unless fixed
  // priority forces port 0.
  always_comb begin
    grant = 2'b00;
    unique case (req)
      2'b01:   grant = 2'b01;
      2'b10:   grant = 2'b10;
      2'b11: begin
        if (fixed_prio || (last_grant == PORT1)) begin
          grant = 2'b01;
        end else begin
          grant = 2'b10;
        end
      end
      default: grant = 2'b00;
    endcase
  end

endmodule

// File: rtl/ejer2_onchip_memory_arbiter.sv
// ejer2_onchip_memory_arbiter
//   Shares one single-port 8192x32 on-chip RAM (1-cycle read latency,
//   byte enables) between two Avalon-MM requesters. One transfer is
//   granted per cycle; read data is routed back to the port that issued
//   the read, one cycle later, with readdatavalid.
//   Ports:
//     clk, reset                 single clock, synchronous active-high reset
//     p0_* / p1_*                Avalon-MM slave side for each requester
//                                (address, byteenable, read, write,
//                                writedata, waitrequest, readdata,
//                                readdatavalid)
//     mem_*                      RAM side (address, byteenable, chipselect,
//                                write, writedata, clken, readdata)
//     proto_err                  sticky flag: read and write seen together
//                                on one port; cleared only by reset
module ejer2_onchip_memory_arbiter
  import ejer2_onchip_mem_pkg::*;
#(
  parameter bit FIXED_PRIO = 1'b0
) (
  input  logic              clk,
  input  logic              reset,

  input  logic [ADDR_W-1:0] p0_address,
  input  logic [BE_W-1:0]   p0_byteenable,
  input  logic              p0_read,
  input  logic              p0_write,
  input  logic [DATA_W-1:0] p0_writedata,
  output logic              p0_waitrequest,
  output logic [DATA_W-1:0] p0_readdata,
  output logic              p0_readdatavalid,

  input  logic [ADDR_W-1:0] p1_address,
  input  logic [BE_W-1:0]   p1_byteenable,
  input  logic              p1_read,
  input  logic              p1_write,
  input  logic [DATA_W-1:0] p1_writedata,
  output logic              p1_waitrequest,
  output logic [DATA_W-1:0] p1_readdata,
  output logic              p1_readdatavalid,

  output logic [ADDR_W-1:0] mem_address,
  output logic [BE_W-1:0]   mem_byteenable,
  output logic              mem_chipselect,
  output logic              mem_write,
  output logic [DATA_W-1:0] mem_writedata,
  output logic              mem_clken,
  input  logic [DATA_W-1:0] mem_readdata,

  output logic              proto_err
);

  logic [1:0]        req;
  logic [1:0]        arb_req;
  logic [1:0]        grant;
  logic              granted;
  port_id_t          last_grant;
  port_id_t          sel;

  logic [ADDR_W-1:0] sel_address;
  logic [BE_W-1:0]   sel_byteenable;
  logic [DATA_W-1:0] sel_writedata;
  logic              sel_write;
  logic              sel_read;

  logic [ADDR_W-1:0] hold_address;
  logic [BE_W-1:0]   hold_byteenable;
  logic [DATA_W-1:0] hold_writedata;

  logic              rd_pend;
  port_id_t          rd_owner;
  logic              rd_valid;

  assign req     = {p1_read | p1_write, p0_read | p0_write};
  // Nothing is granted while reset is high, but waitrequest still follows req.
  assign arb_req = req & {2{~reset}};
  assign granted = |grant;
  assign sel     = grant_to_id(grant);

  ejer2_arb2_rr u_arb (
    .clk        (clk),
    .reset      (reset),
    .req        (arb_req),
    .fixed_prio (FIXED_PRIO),
    .advance    (granted),
    .grant      (grant),
    .last_grant (last_grant)
  );

  assign p0_waitrequest = req[0] & ~grant[0];
  assign p1_waitrequest = req[1] & ~grant[1];

  // Field select for the winning port. A read+write request is treated as
  // a write, so the read qualifier excludes the write case.
  always_comb begin
    sel_address    = p0_address;
    sel_byteenable = p0_byteenable;
    sel_writedata  = p0_writedata;
    sel_write      = p0_write;
    sel_read       = p0_read & ~p0_write;
    if (sel == PORT1) begin
      sel_address    = p1_address;
      sel_byteenable = p1_byteenable;
      sel_writedata  = p1_writedata;
      sel_write      = p1_write;
      sel_read       = p1_read & ~p1_write;
    end
  end

  // Remembers the last granted address/data so the RAM bus stays quiet
  // on idle cycles instead of following whatever the ports are driving.
  always_ff @(posedge clk) begin
    if (reset) begin
      hold_address    <= '0;
      hold_byteenable <= '0;
      hold_writedata  <= '0;
    end else if (granted) begin
      hold_address    <= sel_address;
      hold_byteenable <= mem_byteenable;
      hold_writedata  <= sel_writedata;
    end
  end

  // RAM-side drive: granted port's fields, all byte lanes on reads.
  always_comb begin
    mem_address    = hold_address;
    mem_byteenable = hold_byteenable;
    mem_writedata  = hold_writedata;
    mem_chipselect = 1'b0;
    mem_write      = 1'b0;
    if (granted) begin
      mem_address    = sel_address;
      mem_byteenable = sel_write ? sel_byteenable : '1;
      mem_writedata  = sel_writedata;
      mem_chipselect = 1'b1;
      mem_write      = sel_write;
    end
  end

  assign mem_clken = ~reset;

  // One-deep read-return tracker: the RAM answers exactly one cycle after
  // the read, so one pending bit plus its owner is enough to sustain a
  // read every cycle.
  always_ff @(posedge clk) begin
    if (reset) begin
      rd_pend  <= 1'b0;
      rd_owner <= PORT0;
    end else begin
      rd_pend  <= granted & sel_read;
      rd_owner <= sel;
    end
  end

  // Gating with reset drops a read whose data would return in a reset cycle.
  assign rd_valid         = rd_pend & ~reset;
  assign p0_readdatavalid = rd_valid & (rd_owner == PORT0);
  assign p1_readdatavalid = rd_valid & (rd_owner == PORT1);
  assign p0_readdata      = p0_readdatavalid ? mem_readdata : '0;
  assign p1_readdata      = p1_readdatavalid ? mem_readdata : '0;

  // Sticky protocol error flag.
  always_ff @(posedge clk) begin
    if (reset) begin
      proto_err <= 1'b0;
    end else if ((p0_read & p0_write) | (p1_read & p1_write)) begin
      proto_err <= 1'b1;
    end
  end

endmodule

// File: tb/tb_ejer2_onchip_memory_arbiter.sv
// tb_ejer2_onchip_memory_arbiter
//   Table-driven bench for the two-port memory arbiter. A round-robin
//   instance runs the vector table; a fixed-priority instance sharing the
//   same inputs is checked in a hand-written contention sequence. Each
//   instance has its own behavioural RAM with 1-cycle read latency.
module tb_ejer2_onchip_memory_arbiter;

  logic        clk = 1'b0;
  logic        reset;

  logic [12:0] p0_address, p1_address;
  logic [3:0]  p0_byteenable, p1_byteenable;
  logic        p0_read, p0_write, p1_read, p1_write;
  logic [31:0] p0_writedata, p1_writedata;

  logic        p0_waitrequest, p1_waitrequest;
  logic [31:0] p0_readdata, p1_readdata;
  logic        p0_readdatavalid, p1_readdatavalid;
  logic [12:0] mem_address;
  logic [3:0]  mem_byteenable;
  logic        mem_chipselect, mem_write, mem_clken;
  logic [31:0] mem_writedata, mem_readdata;
  logic        proto_err;

  logic        fp_p0_waitrequest, fp_p1_waitrequest;
  logic [31:0] fp_p0_readdata, fp_p1_readdata;
  logic        fp_p0_readdatavalid, fp_p1_readdatavalid;
  logic [12:0] fp_mem_address;
  logic [3:0]  fp_mem_byteenable;
  logic        fp_mem_chipselect, fp_mem_write, fp_mem_clken;
  logic [31:0] fp_mem_writedata, fp_mem_readdata;
  logic        fp_proto_err;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  ejer2_onchip_memory_arbiter #(.FIXED_PRIO(1'b0)) dut (
    .clk(clk), .reset(reset),
    .p0_address(p0_address), .p0_byteenable(p0_byteenable), .p0_read(p0_read),
    .p0_write(p0_write), .p0_writedata(p0_writedata), .p0_waitrequest(p0_waitrequest),
    .p0_readdata(p0_readdata), .p0_readdatavalid(p0_readdatavalid),
    .p1_address(p1_address), .p1_byteenable(p1_byteenable), .p1_read(p1_read),
    .p1_write(p1_write), .p1_writedata(p1_writedata), .p1_waitrequest(p1_waitrequest),
    .p1_readdata(p1_readdata), .p1_readdatavalid(p1_readdatavalid),
    .mem_address(mem_address), .mem_byteenable(mem_byteenable),
    .mem_chipselect(mem_chipselect), .mem_write(mem_write),
    .mem_writedata(mem_writedata), .mem_clken(mem_clken),
    .mem_readdata(mem_readdata), .proto_err(proto_err)
  );

  ejer2_onchip_memory_arbiter #(.FIXED_PRIO(1'b1)) dut_fp (
    .clk(clk), .reset(reset),
    .p0_address(p0_address), .p0_byteenable(p0_byteenable), .p0_read(p0_read),
    .p0_write(p0_write), .p0_writedata(p0_writedata), .p0_waitrequest(fp_p0_waitrequest),
    .p0_readdata(fp_p0_readdata), .p0_readdatavalid(fp_p0_readdatavalid),
    .p1_address(p1_address), .p1_byteenable(p1_byteenable), .p1_read(p1_read),
    .p1_write(p1_write), .p1_writedata(p1_writedata), .p1_waitrequest(fp_p1_waitrequest),
    .p1_readdata(fp_p1_readdata), .p1_readdatavalid(fp_p1_readdatavalid),
    .mem_address(fp_mem_address), .mem_byteenable(fp_mem_byteenable),
    .mem_chipselect(fp_mem_chipselect), .mem_write(fp_mem_write),
    .mem_writedata(fp_mem_writedata), .mem_clken(fp_mem_clken),
    .mem_readdata(fp_mem_readdata), .proto_err(fp_proto_err)
  );

  // Behavioural single-port RAMs: byte-lane writes, registered reads.
  logic [31:0] ram_rr [8192];
  logic [31:0] ram_fp [8192];

  always @(posedge clk) begin
    if (mem_clken && mem_chipselect) begin
      if (mem_write) begin
        for (int b = 0; b < 4; b++)
          if (mem_byteenable[b]) ram_rr[mem_address][b*8 +: 8] <= mem_writedata[b*8 +: 8];
      end else begin
        mem_readdata <= ram_rr[mem_address];
      end
    end
  end

  always @(posedge clk) begin
    if (fp_mem_clken && fp_mem_chipselect) begin
      if (fp_mem_write) begin
        for (int b = 0; b < 4; b++)
          if (fp_mem_byteenable[b]) ram_fp[fp_mem_address][b*8 +: 8] <= fp_mem_writedata[b*8 +: 8];
      end else begin
        fp_mem_readdata <= ram_fp[fp_mem_address];
      end
    end
  end

  typedef struct {
    logic        rst;
    logic        r0, w0; logic [12:0] a0; logic [3:0] be0; logic [31:0] d0;
    logic        r1, w1; logic [12:0] a1; logic [3:0] be1; logic [31:0] d1;
    logic        e_wait0, e_wait1, e_cs, e_mw; logic [12:0] e_addr; logic [3:0] e_be;
    logic        e_v0; logic [31:0] e_rd0; logic e_v1; logic [31:0] e_rd1; logic e_perr;
  } vec_t;

  vec_t vecs [25];

  // Single comparison; counts every call and reports any difference.
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s actual=0x%08h expected=0x%08h", name, act, exp);
    end
  endtask

  // Drives one cycle's inputs on the falling edge.
  task automatic applyStimulus(input vec_t v);
    @(negedge clk);
    reset         = v.rst;
    p0_read       = v.r0;  p0_write = v.w0;  p0_address = v.a0;
    p0_byteenable = v.be0; p0_writedata = v.d0;
    p1_read       = v.r1;  p1_write = v.w1;  p1_address = v.a1;
    p1_byteenable = v.be1; p1_writedata = v.d1;
  endtask

  // Samples the round-robin instance just before the next rising edge.
  task automatic checkOutput(input int i, input vec_t v);
    #4;
    chk($sformatf("v%0d p0_waitrequest", i), {31'b0, p0_waitrequest}, {31'b0, v.e_wait0});
    chk($sformatf("v%0d p1_waitrequest", i), {31'b0, p1_waitrequest}, {31'b0, v.e_wait1});
    chk($sformatf("v%0d mem_chipselect", i), {31'b0, mem_chipselect}, {31'b0, v.e_cs});
    chk($sformatf("v%0d mem_write", i), {31'b0, mem_write}, {31'b0, v.e_mw});
    chk($sformatf("v%0d mem_clken", i), {31'b0, mem_clken}, {31'b0, ~v.rst});
    if (v.e_cs) begin
      chk($sformatf("v%0d mem_address", i), {19'b0, mem_address}, {19'b0, v.e_addr});
      chk($sformatf("v%0d mem_byteenable", i), {28'b0, mem_byteenable}, {28'b0, v.e_be});
      if (v.e_mw)
        chk($sformatf("v%0d mem_writedata", i), mem_writedata, v.w0 && !v.e_wait0 ? v.d0 : v.d1);
    end
    chk($sformatf("v%0d p0_readdatavalid", i), {31'b0, p0_readdatavalid}, {31'b0, v.e_v0});
    chk($sformatf("v%0d p0_readdata", i), p0_readdata, v.e_rd0);
    chk($sformatf("v%0d p1_readdatavalid", i), {31'b0, p1_readdatavalid}, {31'b0, v.e_v1});
    chk($sformatf("v%0d p1_readdata", i), p1_readdata, v.e_rd1);
    chk($sformatf("v%0d proto_err", i), {31'b0, proto_err}, {31'b0, v.e_perr});
  endtask

  initial begin
    // rst | p0 r w addr be wdata | p1 r w addr be wdata | wait0 wait1 cs mw addr be | v0 rd0 v1 rd1 perr
    vecs[0]  = '{1, 1,0,13'h10,4'hF,32'h0,        0,0,13'h0, 4'h0,32'h0,        1,0,0,0,13'h0, 4'h0, 0,32'h0,        0,32'h0,        0};
    vecs[1]  = vecs[0];
    vecs[2]  = vecs[0];
    vecs[3]  = '{0, 0,1,13'h10,4'hF,32'hDEADBEEF, 0,0,13'h0, 4'h0,32'h0,        0,0,1,1,13'h10,4'hF, 0,32'h0,        0,32'h0,        0};
    vecs[4]  = '{0, 1,0,13'h10,4'h0,32'h0,        0,0,13'h0, 4'h0,32'h0,        0,0,1,0,13'h10,4'hF, 0,32'h0,        0,32'h0,        0};
    vecs[5]  = '{0, 0,0,13'h0, 4'h0,32'h0,        0,0,13'h0, 4'h0,32'h0,        0,0,0,0,13'h0, 4'h0, 1,32'hDEADBEEF, 0,32'h0,        0};
    vecs[6]  = '{0, 0,0,13'h0, 4'h0,32'h0,        0,1,13'h20,4'hF,32'h11223344, 0,0,1,1,13'h20,4'hF, 0,32'h0,        0,32'h0,        0};
    vecs[7]  = '{0, 0,0,13'h0, 4'h0,32'h0,        0,1,13'h20,4'h1,32'h000000AA, 0,0,1,1,13'h20,4'h1, 0,32'h0,        0,32'h0,        0};
    vecs[8]  = '{0, 0,0,13'h0, 4'h0,32'h0,        1,0,13'h20,4'h0,32'h0,        0,0,1,0,13'h20,4'hF, 0,32'h0,        0,32'h0,        0};
    vecs[9]  = '{0, 0,0,13'h0, 4'h0,32'h0,        0,0,13'h0, 4'h0,32'h0,        0,0,0,0,13'h0, 4'h0, 0,32'h0,        1,32'h112233AA, 0};
    vecs[10] = '{0, 1,0,13'h10,4'h0,32'h0,        1,0,13'h20,4'h0,32'h0,        0,1,1,0,13'h10,4'hF, 0,32'h0,        0,32'h0,        0};
    vecs[11] = '{0, 1,0,13'h10,4'h0,32'h0,        1,0,13'h20,4'h0,32'h0,        1,0,1,0,13'h20,4'hF, 1,32'hDEADBEEF, 0,32'h0,        0};
    vecs[12] = '{0, 1,0,13'h10,4'h0,32'h0,        1,0,13'h20,4'h0,32'h0,        0,1,1,0,13'h10,4'hF, 0,32'h0,        1,32'h112233AA, 0};
    vecs[13] = vecs[11];
    vecs[14] = vecs[12];
    vecs[15] = vecs[11];
    vecs[16] = vecs[9];
    vecs[17] = '{0, 0,0,13'h0, 4'h0,32'h0,        1,1,13'h30,4'hF,32'h5555AAAA, 0,0,1,1,13'h30,4'hF, 0,32'h0,        0,32'h0,        0};
    vecs[18] = '{0, 0,0,13'h0, 4'h0,32'h0,        0,0,13'h0, 4'h0,32'h0,        0,0,0,0,13'h0, 4'h0, 0,32'h0,        0,32'h0,        1};
    vecs[19] = '{0, 1,0,13'h30,4'h0,32'h0,        0,0,13'h0, 4'h0,32'h0,        0,0,1,0,13'h30,4'hF, 0,32'h0,        0,32'h0,        1};
    vecs[20] = '{1, 0,0,13'h0, 4'h0,32'h0,        0,0,13'h0, 4'h0,32'h0,        0,0,0,0,13'h0, 4'h0, 0,32'h0,        0,32'h0,        1};
    vecs[21] = '{0, 0,0,13'h0, 4'h0,32'h0,        0,0,13'h0, 4'h0,32'h0,        0,0,0,0,13'h0, 4'h0, 0,32'h0,        0,32'h0,        0};
    vecs[22] = '{0, 1,0,13'h10,4'h0,32'h0,        1,0,13'h30,4'h0,32'h0,        0,1,1,0,13'h10,4'hF, 0,32'h0,        0,32'h0,        0};
    vecs[23] = '{0, 0,0,13'h0, 4'h0,32'h0,        1,0,13'h30,4'h0,32'h0,        0,0,1,0,13'h30,4'hF, 1,32'hDEADBEEF, 0,32'h0,        0};
    vecs[24] = '{0, 0,0,13'h0, 4'h0,32'h0,        0,0,13'h0, 4'h0,32'h0,        0,0,0,0,13'h0, 4'h0, 0,32'h1555AAAA ^ 32'h40000000, 1,32'h5555AAAA, 0};
    vecs[24].e_rd0 = 32'h0;

    reset = 1'b1;
    p0_read = 0; p0_write = 0; p0_address = '0; p0_byteenable = '0; p0_writedata = '0;
    p1_read = 0; p1_write = 0; p1_address = '0; p1_byteenable = '0; p1_writedata = '0;
    repeat (2) @(posedge clk);

    $display("[TB] running %0d table vectors", 25);
    for (int i = 0; i < 25; i++) begin
      applyStimulus(vecs[i]);
      checkOutput(i, vecs[i]);
    end

    // Fixed-priority contention: both ports read every cycle for 4 cycles,
    // port 0 must win each time and port 1 must stay stalled.
    $display("[TB] fixed-priority contention sequence");
    for (int c = 0; c < 4; c++) begin
      vec_t v;
      v = vecs[10];
      applyStimulus(v);
      #4;
      chk($sformatf("fp%0d p0_waitrequest", c), {31'b0, fp_p0_waitrequest}, 32'h0);
      chk($sformatf("fp%0d p1_waitrequest", c), {31'b0, fp_p1_waitrequest}, 32'h1);
      chk($sformatf("fp%0d mem_address", c), {19'b0, fp_mem_address}, 32'h10);
      chk($sformatf("fp%0d p1_readdatavalid", c), {31'b0, fp_p1_readdatavalid}, 32'h0);
      if (c > 0) begin
        chk($sformatf("fp%0d p0_readdatavalid", c), {31'b0, fp_p0_readdatavalid}, 32'h1);
        chk($sformatf("fp%0d p0_readdata", c), fp_p0_readdata, 32'hDEADBEEF);
      end
    end

    // Reset asserted right after a read: the read must be dropped.
    $display("[TB] read then reset sequence");
    applyStimulus(vecs[4]);
    applyStimulus(vecs[20]);
    #4;
    chk("rst-drop p0_readdatavalid", {31'b0, p0_readdatavalid}, 32'h0);
    chk("rst-drop fp p0_readdatavalid", {31'b0, fp_p0_readdatavalid}, 32'h0);
    chk("rst-drop mem_chipselect", {31'b0, mem_chipselect}, 32'h0);
    applyStimulus(vecs[21]);
    #4;
    chk("post-rst p0_readdatavalid", {31'b0, p0_readdatavalid}, 32'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
